// File: rtl/img_mem_pkg.sv
// img_mem_pkg: shared FSM states, MMIO constants and byte-lane helper for image_mem_responder
package img_mem_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, FIN} state_t;

    localparam logic [15:0] MMIO_PREFIX   = 16'hFFFF;
    localparam logic [31:0] DONE_ADDR_DEF = 32'hFFFF_FFF0;

    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] sel);
        return w[8*sel +: 8];
    endfunction

endpackage

// File: rtl/image_mem_responder_if.sv
// image_mem_responder_if: CPU data port plus host byte-stream handshakes of the image responder
interface image_mem_responder_if;

    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        cpu_reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        done;

    modport master (
        output MemWrite, ALUResult, WriteData, start, in_valid, in_data, out_ready,
        input  ReadData, cpu_reset, in_ready, out_valid, out_data, done
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData, start, in_valid, in_data, out_ready,
        output ReadData, cpu_reset, in_ready, out_valid, out_data, done
    );

endinterface

// File: rtl/img_word_ram.sv
// img_word_ram: word RAM with one synchronous write port and one asynchronous read port
module img_word_ram #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Contents are deliberately not reset; only written words are meaningful
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/image_mem_responder.sv
// image_mem_responder: data-port responder owning the image RAM; host FSM loads, runs the core, dumps the result.
// Optional IMG_MEM_CYCLE_CNT_EN: saturating RUN-cycle counter on run_cycles and at MMIO DONE_ADDR+4.
module image_mem_responder
    import img_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          IMG_BYTES   = 256,
    parameter int          SRC_BASE_W  = 0,
    parameter int          RES_BASE_W  = 512,
    parameter logic [31:0] DONE_ADDR   = DONE_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    image_mem_responder_if.slave  bus
`ifdef IMG_MEM_CYCLE_CNT_EN
    ,
    output logic [31:0]           run_cycles
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = $clog2(IMG_BYTES + 1);
    localparam int WW = $clog2(IMG_BYTES / 4 + 1);

    state_t        state_q, state_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [WW-1:0] word_q, word_d;
    logic [23:0]   sh_q, sh_d;
    logic          ov_q, ov_d;
    logic [7:0]    od_q, od_d;

    logic          mmio, beat, host_we, cpu_we, done_wr, dump_ld, dump_end;
    logic [AW-1:0] cpu_idx, waddr, raddr;
    logic [31:0]   wdata, rdata;

    assign mmio     = bus.ALUResult[31:16] == MMIO_PREFIX;
    assign cpu_idx  = bus.ALUResult[AW+1:2];
    assign beat     = state_q == LOAD && bus.in_valid;
    assign host_we  = beat && byte_q[1:0] == 2'd3;
    assign cpu_we   = state_q == RUN && bus.MemWrite && !mmio;
    assign done_wr  = state_q == RUN && bus.MemWrite && bus.ALUResult == DONE_ADDR;
    assign dump_ld  = state_q == DUMP && (!ov_q || bus.out_ready) && byte_q != BW'(IMG_BYTES);
    assign dump_end = state_q == DUMP && ov_q && bus.out_ready && byte_q == BW'(IMG_BYTES);

    // Host and CPU writes never coincide: each is only live in its own state
    assign waddr = host_we ? AW'(SRC_BASE_W) + AW'(word_q) : cpu_idx;
    assign wdata = host_we ? {bus.in_data, sh_q} : bus.WriteData;
    assign raddr = state_q == DUMP ? AW'(RES_BASE_W) + AW'(byte_q[BW-1:2]) : cpu_idx;

    img_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk    (clk),
        .we_i   (host_we || cpu_we),
        .waddr_i(waddr),
        .wdata_i(wdata),
        .raddr_i(raddr),
        .rdata_o(rdata)
    );

    assign bus.in_ready  = state_q == LOAD;
    assign bus.cpu_reset = state_q != RUN;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.done      = state_q == FIN;

    // Next-state: byte assembly in LOAD, DONE detection in RUN, registered byte stream in DUMP
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        word_d  = word_q;
        sh_d    = sh_q;
        ov_d    = ov_q;
        od_d    = od_q;
        case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: begin
                if (beat) begin
                    sh_d   = {bus.in_data, sh_q[23:8]};
                    byte_d = byte_q + 1'b1;
                    if (host_we) word_d = word_q + 1'b1;
                    if (byte_q == BW'(IMG_BYTES - 1)) begin
                        state_d = RUN;
                        byte_d  = '0;
                        word_d  = '0;
                    end
                end
            end
            RUN: if (done_wr) state_d = DUMP;
            DUMP: begin
                if (dump_ld) begin
                    od_d   = byte_lane(rdata, byte_q[1:0]);
                    ov_d   = 1'b1;
                    byte_d = byte_q + 1'b1;
                end else if (dump_end) begin
                    ov_d    = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                if (bus.start) begin
                    state_d = LOAD;
                    byte_d  = '0;
                    word_d  = '0;
                    sh_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, partial word and output byte; reset drops any partial word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            byte_q  <= '0;
            word_q  <= '0;
            sh_q    <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

`ifdef IMG_MEM_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Zero on RUN entry, count every RUN cycle with saturation, hold everywhere else
    always_comb begin
        cyc_d = (state_q == LOAD && state_d == RUN) ? '0 :
                (state_q == RUN && cyc_q != '1)    ? cyc_q + 32'd1 : cyc_q;
    end

    // Cycle counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign run_cycles   = cyc_q;
    assign bus.ReadData = !mmio ? rdata : (bus.ALUResult == DONE_ADDR + 32'd4) ? cyc_q : '0;
`else
    assign bus.ReadData = mmio ? '0 : rdata;
`endif

endmodule

// File: tb/tb_image_mem_responder.sv
// tb_image_mem_responder: randomized load/run/dump jobs checked against an array model of the image and result
module tb_image_mem_responder;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    int   run_ticks;
    logic [7:0]  img [256];
    logic [31:0] res [64];

    image_mem_responder_if bus ();

`ifdef IMG_MEM_CYCLE_CNT_EN
    logic [31:0] run_cycles;
`endif

    image_mem_responder dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef IMG_MEM_CYCLE_CNT_EN
        ,
        .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] img_word(input int w);
        return {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
    endfunction

    function automatic logic [7:0] res_byte(input int k);
        return 8'(res[k/4] >> (8 * (k % 4)));
    endfunction

    function automatic logic near(input logic [31:0] got, input int exp);
        return (int'(got) >= exp - 1) && (int'(got) <= exp + 1);
    endfunction

    task automatic check_reset(input string p);
        chk({p, "_cpu_reset"}, bus.cpu_reset, 1);
        chk({p, "_in_ready"}, bus.in_ready, 0);
        chk({p, "_out_valid"}, bus.out_valid, 0);
        chk({p, "_out_data"}, bus.out_data, 0);
        chk({p, "_done"}, bus.done, 0);
    endtask

    task automatic pulse_start;
        bus.start = 1;
        tick;
        bus.start = 0;
    endtask

    task automatic load(input int from, input int to, output int got);
        int  guard;
        bit  acc;
        got   = from;
        guard = 0;
        while (got < to && guard < 4000) begin
            bus.in_valid = ($urandom_range(3) != 0);
            bus.in_data  = img[got];
            acc = bus.in_valid && bus.in_ready;
            tick;
            guard++;
            if (acc) got++;
        end
        bus.in_valid = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.MemWrite  = 0;
        bus.ALUResult = addr;
        #1;
        chk(tag, bus.ReadData, exp);
        tick;
        run_ticks++;
    endtask

    task automatic done_write;
        bus.MemWrite  = 1;
        bus.ALUResult = 32'hFFFF_FFF0;
        bus.WriteData = 32'h1;
        tick;
        run_ticks++;
        bus.MemWrite  = 0;
        bus.ALUResult = 0;
    endtask

    task automatic dump(input bit rnd);
        int k;
        int guard;
        bit acc;
        k     = 0;
        guard = 0;
        while (k < 256 && guard < 3000) begin
            if (bus.out_valid) chk("dump_byte", bus.out_data, res_byte(k));
            bus.out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            acc = bus.out_valid && bus.out_ready;
            tick;
            guard++;
            if (acc) k++;
        end
        bus.out_ready = 0;
        chk("dump_count", k, 256);
        chk("dump_valid_low", bus.out_valid, 0);
        chk("done_high", bus.done, 1);
    endtask

    initial begin
        int got;
        int w;
        bus.MemWrite  = 0;
        bus.ALUResult = 0;
        bus.WriteData = 0;
        bus.start     = 0;
        bus.in_valid  = 0;
        bus.in_data   = 0;
        bus.out_ready = 0;
        reset = 1;
        repeat (2) tick;
        check_reset("rst");
        reset = 0;
        tick;
        chk("idle_in_ready", bus.in_ready, 0);

        // Job 1: load random image, exercise RUN, dump with random backpressure
        pulse_start;
        chk("load_in_ready", bus.in_ready, 1);
        foreach (img[i]) img[i] = 8'($urandom);
        load(0, 255, got);
        chk("beats_255", got, 255);
        chk("cpu_rst_load", bus.cpu_reset, 1);
        load(255, 256, got);
        chk("beats_256", got, 256);
        chk("cpu_rst_run", bus.cpu_reset, 0);
        chk("in_ready_run", bus.in_ready, 0);
        run_ticks = 0;
        pulse_start;
        run_ticks++;
        chk("start_ignored", bus.cpu_reset, 0);
        rd_chk("ram0", 32'h0, img_word(0));
        rd_chk("ram63", 32'd252, img_word(63));
        repeat (4) begin
            w = $urandom_range(63);
            rd_chk("ram_rand", 32'(w * 4), img_word(w));
        end
        foreach (res[i]) res[i] = $urandom;
        res[0] = 32'hA1B2C3D4;
        for (int i = 0; i < 64; i++) begin
            bus.MemWrite  = 1;
            bus.ALUResult = 32'h800 + 32'(4 * i);
            bus.WriteData = res[i];
            tick;
            run_ticks++;
            if (i % 16 == 5) begin
                bus.ALUResult = 32'hFFFF_0800;
                bus.WriteData = $urandom;
                tick;
                run_ticks++;
            end
        end
        bus.MemWrite = 0;
        rd_chk("res0", 32'h800, 32'hA1B2C3D4);
        repeat (3) begin
            w = $urandom_range(63);
            rd_chk("res_rand", 32'h800 + 32'(w * 4), res[w]);
        end
        rd_chk("mmio_rd", 32'hFFFF_1234, 0);
`ifndef IMG_MEM_CYCLE_CNT_EN
        rd_chk("cyc_absent", 32'hFFFF_FFF4, 0);
`endif
        while (run_ticks < 99) begin
            tick;
            run_ticks++;
        end
`ifdef IMG_MEM_CYCLE_CNT_EN
        bus.ALUResult = 32'hFFFF_FFF4;
        #1;
        chk("cyc_mmio_run", near(bus.ReadData, run_ticks), 1);
`endif
        done_write;
        chk("cpu_rst_dump", bus.cpu_reset, 1);
        chk("dump_ov0", bus.out_valid, 0);
        tick;
        chk("first_valid", bus.out_valid, 1);
        chk("first_byte", bus.out_data, 8'hD4);
        dump(1);
`ifdef IMG_MEM_CYCLE_CNT_EN
        chk("cyc_port_fin", near(run_cycles, run_ticks), 1);
        repeat (5) tick;
        chk("cyc_frozen", near(run_cycles, run_ticks), 1);
        bus.ALUResult = 32'hFFFF_FFF4;
        #1;
        chk("cyc_mmio_fin", near(bus.ReadData, run_ticks), 1);
        bus.ALUResult = 0;
`endif

        // Job 2: abort mid-load with asynchronous reset
        pulse_start;
        foreach (img[i]) img[i] = 8'($urandom);
        load(0, 6, got);
        #2 reset = 1;
        #1 check_reset("async_rst");
        tick;
        reset = 0;
        tick;

        // Job 3: clean job after the abort, dump without backpressure
        pulse_start;
        foreach (img[i]) img[i] = 8'($urandom);
        load(0, 256, got);
        chk("beats_job3", got, 256);
        run_ticks = 0;
        rd_chk("job3_ram0", 32'h0, img_word(0));
        rd_chk("job3_ram1", 32'h4, img_word(1));
        rd_chk("job3_ram63", 32'd252, img_word(63));
        done_write;
        dump(0);
`ifdef IMG_MEM_CYCLE_CNT_EN
        chk("cyc_job3", near(run_cycles, run_ticks), 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/image_mem_responder.md
Name: image_mem_responder

Overview:
- Memory-side responder for the pipelined ARM core's data port.
- Consumes MemWrite/ALUResult/WriteData and returns ReadData.
- Owns the word RAM holding the source image and the equalized result.
- A host-side FSM streams the image in byte by byte, holds the core in reset, releases it to run, then streams the result out once the core writes a completion register.

Parameters:
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of 2).
- IMG_BYTES, 256, image size in bytes; must be a multiple of 4 and ≤ 4*DEPTH_WORDS/2.
- SRC_BASE_W, 0, word index where loaded image bytes are written.
- RES_BASE_W, 512, word index the dump phase reads from.
- DONE_ADDR, 32'hFFFF_FFF0, MMIO byte address; a CPU write here ends the run.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  CPU store strobe.
- ALUResult  in  32  CPU byte address.
- WriteData  in  32  CPU store data.
- ReadData  out  32  CPU load data, combinational from ALUResult.
- cpu_reset  out  1  drives core reset; high except in RUN.
- start  in  1  host pulse: begin a load/run/dump job.
- in_valid  in  1  host byte valid.
- in_data  in  8  host image byte.
- in_ready  out  1  block accepts a byte.
- out_valid  out  1  result byte valid.
- out_data  out  8  result byte.
- out_ready  in  1  host accepts a result byte.
- done  out  1  job complete.

Behaviour:
- Reset values: FSM=IDLE, cpu_reset=1, in_ready=0, out_valid=0, out_data=0, done=0, byte/word counters=0. RAM contents are not reset.
- Word index = ALUResult[log2(DEPTH_WORDS)+1:2]. The RAM is synchronous-write and asynchronous-read.
- Addresses with ALUResult[31:16]==16'hFFFF are MMIO: they never write RAM and read 0, except as noted in Optional Feature.
- IDLE:
  - start=1 → LOAD.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1. Each in_valid&in_ready beat places in_data into a shift register, little-endian (byte 0 → bits 7:0).
  - On every 4th beat, the assembled word is written to RAM[SRC_BASE_W+word_cnt] in the same cycle as that beat.
  - After beat IMG_BYTES → RUN. in_ready drops in the cycle the state changes.
- RUN:
  - cpu_reset=0. MemWrite=1 with a non-MMIO address writes WriteData to RAM at the next clk edge.
  - MemWrite=1 with ALUResult==DONE_ADDR → DUMP. cpu_reset=1 from the following cycle.
  - A DONE write is the only RUN exit.
- DUMP:
  - out_data is registered. The first byte is presented 1 cycle after entering DUMP, from RAM[RES_BASE_W] bits 7:0.
  - out_valid stays high and out_data stable until out_ready. Then the next byte loads the next cycle (no bubble required; bubble allowed).
  - Byte order is little-endian within each word.
  - After byte IMG_BYTES is accepted → FIN with out_valid=0.
- FIN:
  - done=1.
  - start=1 → clear done, reset counters → LOAD.
- In LOAD/DUMP/FIN/IDLE, CPU MemWrite is ignored because the core is held in reset.
- Counters are exactly wide enough for IMG_BYTES. They do not wrap within a job.
- Asynchronous reset at any point returns to IDLE immediately. A partially assembled word is discarded.

Optional Feature:
- Macro: IMG_MEM_CYCLE_CNT_EN.
- When defined:
  - A 32-bit counter clears on entry to RUN and increments every RUN cycle.
  - It saturates at 32'hFFFF_FFFF and freezes outside RUN.
  - CPU reads at DONE_ADDR+4 return it.
  - Output port run_cycles[31:0] mirrors it.
- When undefined: no counter, no run_cycles port, and DONE_ADDR+4 reads 0.

Decomposition:
- Package img_mem_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DUMP, FIN);
  - MMIO_PREFIX=16'hFFFF;
  - the default DONE_ADDR;
  - a byte-lane select function.
- One sub-module: img_word_ram (single write port, async read port, DEPTH_WORDS parameter).
- Host write, CPU write, and the dump read mux are in the top.

Test Plan:
1. start pulse, then bytes 0x00..0xFF with in_valid always high → 256 beats accepted; RAM[0]=32'h03020100, RAM[63]=32'hFFFEFDFC; cpu_reset falls the cycle after beat 256.
2. RUN: MemWrite, ALUResult=32'h0000_0800, WriteData=32'hA1B2C3D4 → next cycle ReadData=32'hA1B2C3D4 at ALUResult=32'h800 (RAM[512]).
3. RUN: write 32'h1 to 32'hFFFF_FFF0 → cpu_reset=1 next cycle; first out_data=8'hD4, then 8'hC3, 8'hB2, 8'hA1.
4. DUMP with out_ready toggling 1/0 → out_data is held while out_ready=0; exactly 256 bytes; done=1 after the last accept.
5. Reset asserted mid-LOAD after 6 bytes, then a new job → RAM[0] holds the new bytes, no stale partial word; all outputs at their reset values while reset is high.
6. IMG_MEM_CYCLE_CNT_EN: 100 RUN cycles then the DONE write → a read of 32'hFFFF_FFF4 returns 100 (±1 per the defined entry cycle); run_cycles stays frozen in FIN.
